xf100_imem_arb: RTL and testbench

Arbiter and sequencer for the single-port instruction memory shared by the core fetch unit and the bench/debug loader. After reset it runs in BOOT, where only the loader may access memory to write the program image. Once boot_done is seen it moves to RUN, where fetch has priority and the loader is serviced on idle cycles or after a bounded starvation window. It sits between xf100_core's fetch port, the loader and the imem macro.

---
 rtl/xf100_imem_pkg.sv | 14 +
 rtl/xf100_sat_cnt.sv | 35 +++
 rtl/xf100_imem_arb.sv | 95 +++++++++
 tb/tb_xf100_imem_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/xf100_imem_pkg.sv
// Shared types and sizing for the xf100 instruction-memory arbiter.
package xf100_imem_pkg;

  localparam int INSTR_SIZE     = 32;
  localparam int IMEM_AW        = 10;
  localparam int IMEM_DW        = INSTR_SIZE;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xf100_sat_cnt.sv
// Saturating up-counter with clear priority and an at-maximum flag.
module xf100_sat_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign max_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xf100_imem_arb.sv
// Single-port imem arbiter: loader-only BOOT phase, then fetch-priority RUN
// phase with a bounded starvation window for the loader.
module xf100_imem_arb
  import xf100_imem_pkg::*;
#(
  parameter int AW         = IMEM_AW,
  parameter int DW         = IMEM_DW,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  input  logic          fe_req_valid,
  output logic          fe_req_ready,
  input  logic [AW-1:0] fe_req_addr,
  output logic          fe_rsp_valid,
  output logic [DW-1:0] fe_rsp_data,
  input  logic          ld_req_valid,
  output logic          ld_req_ready,
  input  logic          ld_req_we,
  input  logic [AW-1:0] ld_req_addr,
  input  logic [DW-1:0] ld_req_wdata,
  output logic          ld_rsp_valid,
  output logic [DW-1:0] ld_rsp_data,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          in_boot
);

  arb_state_e state_q;
  logic       fe_rsp_q, ld_rsp_q;
  logic       boot, starve_max, force_ld;
  logic       fe_gnt, ld_gnt;
  logic       starve_inc, starve_clr;

  // Grants are masked while rst is high so the memory sees no access mid-reset.
  always_comb begin
    boot     = (state_q == BOOT);
    force_ld = !boot && ld_req_valid && starve_max;
    fe_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    if (!rst) begin
      if (boot) begin
        ld_gnt = ld_req_valid;
      end else begin
        ld_gnt = ld_req_valid && (force_ld || !fe_req_valid);
        fe_gnt = fe_req_valid && !force_ld;
      end
    end
  end

  assign starve_inc = !boot && ld_req_valid && !ld_gnt;
  assign starve_clr = boot || !ld_req_valid || ld_gnt;

  xf100_sat_cnt #(
    .MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(starve_inc),
    .clr_i(starve_clr),
    .max_o(starve_max)
  );

  assign fe_req_ready = fe_gnt;
  assign ld_req_ready = ld_gnt;
  assign mem_cs       = fe_gnt || ld_gnt;
  assign mem_we       = ld_gnt && ld_req_we;
  assign mem_addr     = fe_gnt ? fe_req_addr : (ld_gnt ? ld_req_addr : '0);
  assign mem_wdata    = ld_gnt ? ld_req_wdata : '0;
  assign in_boot      = boot || rst;

  assign fe_rsp_valid = fe_rsp_q;
  assign ld_rsp_valid = ld_rsp_q;
  assign fe_rsp_data  = fe_rsp_q ? mem_rdata : '0;
  assign ld_rsp_data  = ld_rsp_q ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      fe_rsp_q <= 1'b0;
      ld_rsp_q <= 1'b0;
    end else begin
      if (boot && boot_done) begin
        state_q <= RUN;
      end
      fe_rsp_q <= fe_gnt;
      ld_rsp_q <= ld_gnt && !ld_req_we;
    end
  end

endmodule

// File: tb/tb_xf100_imem_arb.sv
// Bench for xf100_imem_arb: directed scenarios plus randomized traffic against
// a behavioural arbiter/memory model.
module tb_xf100_imem_arb;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        boot_done;
  logic        fe_req_valid;
  logic        fe_req_ready;
  logic [9:0]  fe_req_addr;
  logic        fe_rsp_valid;
  logic [31:0] fe_rsp_data;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic        ld_req_we;
  logic [9:0]  ld_req_addr;
  logic [31:0] ld_req_wdata;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        mem_cs;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        in_boot;

  int n_vec = 0;
  int n_err = 0;

  xf100_imem_arb #(
    .AW(10),
    .DW(32),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .fe_req_valid(fe_req_valid), .fe_req_ready(fe_req_ready), .fe_req_addr(fe_req_addr),
    .fe_rsp_valid(fe_rsp_valid), .fe_rsp_data(fe_rsp_data),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
    .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .in_boot(in_boot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory macro, 1-cycle read latency.
  logic [31:0] macro_mem [0:1023];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) macro_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= macro_mem[mem_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  bit          m_boot = 1'b1;
  int          m_starve = 0;
  bit          m_fe_pend = 1'b0, m_ld_pend = 1'b0;
  logic [31:0] m_fe_exp = '0, m_ld_exp = '0;
  bit          p_fe_g = 1'b0, p_ld_g = 1'b0;
  bit          e_cs, e_we, e_inboot;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata, e_fe_d, e_ld_d;

  // Advance the model across the clock edge just taken with the held inputs.
  task automatic model_edge();
    if (rst) begin
      m_boot = 1'b1; m_starve = 0; m_fe_pend = 1'b0; m_ld_pend = 1'b0;
    end else begin
      if (p_ld_g && ld_req_we) ref_mem[ld_req_addr] = ld_req_wdata;
      m_fe_pend = p_fe_g;
      m_fe_exp  = ref_mem[fe_req_addr];
      m_ld_pend = p_ld_g && !ld_req_we;
      m_ld_exp  = ref_mem[ld_req_addr];
      if (!m_boot && ld_req_valid && !p_ld_g) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      if (m_boot && boot_done) m_boot = 1'b0;
    end
  endtask

  task automatic predict();
    p_fe_g = 1'b0;
    p_ld_g = 1'b0;
    if (!rst) begin
      if (m_boot) p_ld_g = ld_req_valid;
      else if (ld_req_valid && m_starve == SMAX) p_ld_g = 1'b1;
      else if (fe_req_valid) p_fe_g = 1'b1;
      else p_ld_g = ld_req_valid;
    end
    e_cs     = p_fe_g || p_ld_g;
    e_we     = p_ld_g && ld_req_we;
    e_addr   = p_fe_g ? fe_req_addr : (p_ld_g ? ld_req_addr : 10'd0);
    e_wdata  = p_ld_g ? ld_req_wdata : 32'd0;
    e_inboot = m_boot || rst;
    e_fe_d   = m_fe_pend ? m_fe_exp : 32'd0;
    e_ld_d   = m_ld_pend ? m_ld_exp : 32'd0;
  endtask

  task automatic apply(input bit r, input bit bd, input bit fv, input logic [9:0] fa,
                       input bit lv, input bit lwe, input logic [9:0] la, input logic [31:0] lwd);
    @(negedge clk);
    model_edge();
    rst = r; boot_done = bd;
    fe_req_valid = fv; fe_req_addr = fa;
    ld_req_valid = lv; ld_req_we = lwe; ld_req_addr = la; ld_req_wdata = lwd;
    #1;
    predict();
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b1, 10'd7, 1'b1, 1'b1, 10'd3, 32'hAAAA);
    apply(1'b1, 1'b0, 1'b1, 10'd7, 1'b1, 1'b1, 10'd3, 32'hAAAA);
    n_vec++; if ({fe_req_ready, ld_req_ready, mem_cs, mem_we} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {fe_req_ready, ld_req_ready, mem_cs, mem_we}); end
    n_vec++; if ({fe_rsp_valid, ld_rsp_valid} !== 2'b0) begin n_err++; $display("FAIL reset_rspv: got %b want 00", {fe_rsp_valid, ld_rsp_valid}); end
    n_vec++; if ({mem_addr, mem_wdata} !== 42'd0) begin n_err++; $display("FAIL reset_memdata: got %h want 0", {mem_addr, mem_wdata}); end
    n_vec++; if ({fe_rsp_data, ld_rsp_data} !== 64'd0) begin n_err++; $display("FAIL reset_rspdata: got %h want 0", {fe_rsp_data, ld_rsp_data}); end
    n_vec++; if (in_boot !== 1'b1) begin n_err++; $display("FAIL reset_in_boot: got %b want 1", in_boot); end
  endtask

  task automatic test_boot_load();
    logic [31:0] img [3];
    img[0] = 32'h13; img[1] = 32'h6F; img[2] = 32'h93;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, 10'(i + 1), 1'b1, 1'b1, 10'(i), img[i]);
      n_vec++; if (fe_req_ready !== 1'b0) begin n_err++; $display("FAIL boot_fe_ready[%0d]: got %b want 0", i, fe_req_ready); end
      n_vec++; if ({ld_req_ready, mem_we} !== 2'b11) begin n_err++; $display("FAIL boot_ld_we[%0d]: got %b want 11", i, {ld_req_ready, mem_we}); end
      n_vec++; if ({mem_addr, mem_wdata} !== {10'(i), img[i]}) begin n_err++; $display("FAIL boot_mem[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, i, img[i]); end
      n_vec++; if ({fe_rsp_valid, ld_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL boot_rspv[%0d]: got %b want 00", i, {fe_rsp_valid, ld_rsp_valid}); end
    end
  endtask

  task automatic test_transition();
    apply(1'b0, 1'b1, 1'b1, 10'd1, 1'b1, 1'b1, 10'd3, 32'h17);
    n_vec++; if ({ld_req_ready, fe_req_ready, mem_we, in_boot} !== 4'b1011) begin n_err++; $display("FAIL trans_grant: got %b want 1011", {ld_req_ready, fe_req_ready, mem_we, in_boot}); end
    apply(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (in_boot !== 1'b0) begin n_err++; $display("FAIL trans_in_boot: got %b want 0", in_boot); end
    n_vec++; if ({fe_req_ready, mem_we, mem_addr} !== {2'b10, 10'd1}) begin n_err++; $display("FAIL trans_fe_grant: got %b/%b/%h want 1/0/001", fe_req_ready, mem_we, mem_addr); end
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (fe_rsp_valid !== 1'b1 || fe_rsp_data !== 32'h6F) begin n_err++; $display("FAIL trans_fe_rsp: got %b/%h want 1/0000006f", fe_rsp_valid, fe_rsp_data); end
  endtask

  task automatic test_starvation();
    for (int i = 0; i <= SMAX; i++) begin
      apply(1'b0, 1'b0, 1'b1, 10'(i), 1'b1, 1'b0, 10'd2, 32'd0);
      n_vec++; if ({fe_req_ready, ld_req_ready} !== {i != SMAX, i == SMAX}) begin n_err++; $display("FAIL starve_grant[%0d]: got fe/ld %b%b want %b%b", i, fe_req_ready, ld_req_ready, i != SMAX, i == SMAX); end
    end
    apply(1'b0, 1'b0, 1'b1, 10'd9, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 32'h93) begin n_err++; $display("FAIL starve_ld_rsp: got %b/%h want 1/00000093", ld_rsp_valid, ld_rsp_data); end
    n_vec++; if ({fe_rsp_valid, fe_req_ready} !== 2'b01) begin n_err++; $display("FAIL starve_fe_after: got %b want 01", {fe_rsp_valid, fe_req_ready}); end
  endtask

  task automatic test_idle_steal();
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'd0);
    n_vec++; if ({ld_req_ready, fe_req_ready, mem_addr} !== {2'b10, 10'd2}) begin n_err++; $display("FAIL steal_grant: got %b/%b/%h want 1/0/002", ld_req_ready, fe_req_ready, mem_addr); end
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 32'h93) begin n_err++; $display("FAIL steal_ld_rsp: got %b/%h want 1/00000093", ld_rsp_valid, ld_rsp_data); end
    n_vec++; if (fe_rsp_valid !== 1'b0) begin n_err++; $display("FAIL steal_fe_rspv: got %b want 0", fe_rsp_valid); end
  endtask

  task automatic test_reset_mid_read();
    apply(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (fe_req_ready !== 1'b1) begin n_err++; $display("FAIL mid_fe_grant: got %b want 1", fe_req_ready); end
    apply(1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if ({fe_req_ready, mem_cs, in_boot} !== 3'b001) begin n_err++; $display("FAIL mid_during_rst: got %b want 001", {fe_req_ready, mem_cs, in_boot}); end
    apply(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (fe_rsp_valid !== 1'b0 || fe_rsp_data !== 32'd0) begin n_err++; $display("FAIL mid_rsp_dropped: got %b/%h want 0/00000000", fe_rsp_valid, fe_rsp_data); end
    n_vec++; if ({fe_req_ready, in_boot} !== 2'b01) begin n_err++; $display("FAIL mid_after_rst: got %b want 01", {fe_req_ready, in_boot}); end
  endtask

  task automatic test_raw();
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    n_vec++; if ({ld_req_ready, mem_we} !== 2'b11) begin n_err++; $display("FAIL raw_write: got %b want 11", {ld_req_ready, mem_we}); end
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0);
    n_vec++; if ({ld_req_ready, mem_we} !== 2'b10) begin n_err++; $display("FAIL raw_read: got %b want 10", {ld_req_ready, mem_we}); end
    apply(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    n_vec++; if (ld_rsp_valid !== 1'b1 || ld_rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_rsp: got %b/%h want 1/deadbeef", ld_rsp_valid, ld_rsp_data); end
  endtask

  task automatic test_random();
    bit fv, lv, lwe, r, bd;
    logic [9:0]  fa, la;
    logic [31:0] lwd;
    for (int c = 0; c < 3000; c++) begin
      // Requesters hold their request until the model says it was accepted.
      if (fe_req_valid && !p_fe_g && !rst) begin fv = 1'b1; fa = fe_req_addr; end
      else begin fv = ($urandom_range(0, 3) != 0); fa = 10'($urandom_range(0, 15)); end
      if (ld_req_valid && !p_ld_g && !rst) begin lv = 1'b1; lwe = ld_req_we; la = ld_req_addr; lwd = ld_req_wdata; end
      else begin lv = ($urandom_range(0, 1) != 0); lwe = ($urandom_range(0, 2) == 0); la = 10'($urandom_range(0, 15)); lwd = $urandom; end
      r  = ($urandom_range(0, 199) == 0);
      bd = ($urandom_range(0, 19) == 0);
      apply(r, bd, fv, fa, lv, lwe, la, lwd);
      n_vec++; if (fe_req_ready !== p_fe_g) begin n_err++; $display("FAIL rnd_fe_ready @%0d: got %b want %b", c, fe_req_ready, p_fe_g); end
      n_vec++; if (ld_req_ready !== p_ld_g) begin n_err++; $display("FAIL rnd_ld_ready @%0d: got %b want %b", c, ld_req_ready, p_ld_g); end
      n_vec++; if (mem_cs !== e_cs) begin n_err++; $display("FAIL rnd_mem_cs @%0d: got %b want %b", c, mem_cs, e_cs); end
      n_vec++; if (mem_we !== e_we) begin n_err++; $display("FAIL rnd_mem_we @%0d: got %b want %b", c, mem_we, e_we); end
      n_vec++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_mem_addr @%0d: got %h want %h", c, mem_addr, e_addr); end
      n_vec++; if (mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", c, mem_wdata, e_wdata); end
      n_vec++; if (in_boot !== e_inboot) begin n_err++; $display("FAIL rnd_in_boot @%0d: got %b want %b", c, in_boot, e_inboot); end
      n_vec++; if (fe_rsp_valid !== m_fe_pend) begin n_err++; $display("FAIL rnd_fe_rspv @%0d: got %b want %b", c, fe_rsp_valid, m_fe_pend); end
      n_vec++; if (ld_rsp_valid !== m_ld_pend) begin n_err++; $display("FAIL rnd_ld_rspv @%0d: got %b want %b", c, ld_rsp_valid, m_ld_pend); end
      n_vec++; if (fe_rsp_data !== e_fe_d) begin n_err++; $display("FAIL rnd_fe_rspd @%0d: got %h want %h", c, fe_rsp_data, e_fe_d); end
      n_vec++; if (ld_rsp_data !== e_ld_d) begin n_err++; $display("FAIL rnd_ld_rspd @%0d: got %h want %h", c, ld_rsp_data, e_ld_d); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      macro_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    mem_rdata = '0;
    rst = 1'b1; boot_done = 1'b0;
    fe_req_valid = 1'b0; fe_req_addr = '0;
    ld_req_valid = 1'b0; ld_req_we = 1'b0; ld_req_addr = '0; ld_req_wdata = '0;
    test_reset();
    test_boot_load();
    test_transition();
    test_starvation();
    test_idle_steal();
    test_reset_mid_read();
    test_raw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
